// File: rtl/handshake_pipe_pkg.sv
// Shared constants for the handshake pipe chain: register-mode selectors.
package handshake_pipe_pkg;
   localparam int MODE_BYPASS = 0;
   localparam int MODE_VALID  = 1;
   localparam int MODE_READY  = 2;
   localparam int MODE_BOTH   = 3;
endpackage

// File: rtl/handshake_pipe_stage.sv
// One valid/ready stage: forward reg (1 cycle, comb ready), skid (0 cycles, registered ready),
// or both (1 cycle, registered ready, holds two entries). Flush clears valid flags only.
module handshake_pipe_stage
   import handshake_pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int MODE   = MODE_BOTH
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              flush_i,
   input  logic              in_vld_i,
   input  logic [DATA_W-1:0] in_dat_i,
   output logic              in_rdy_o,
   output logic              out_vld_o,
   output logic [DATA_W-1:0] out_dat_o,
   input  logic              out_rdy_i
);
   if (MODE == MODE_VALID) begin : g_valid
      logic              vld_q, vld_d;
      logic [DATA_W-1:0] dat_q, dat_d;

      assign in_rdy_o  = !vld_q || out_rdy_i;
      assign out_vld_o = vld_q;
      assign out_dat_o = dat_q;

      always_comb begin
         vld_d = vld_q;
         dat_d = dat_q;
         if (in_rdy_o) begin
            vld_d = in_vld_i;
            if (in_vld_i) dat_d = in_dat_i;
         end
         if (flush_i) vld_d = 1'b0;
      end

      always_ff @(posedge clk_i) begin
         if (!rst_n_i) begin
            vld_q <= 1'b0;
            dat_q <= '0;
         end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
         end
      end
   end else if (MODE == MODE_READY) begin : g_ready
      logic              skid_vld_q, skid_vld_d;
      logic [DATA_W-1:0] skid_dat_q, skid_dat_d;

      assign in_rdy_o  = !skid_vld_q;
      assign out_vld_o = skid_vld_q || in_vld_i;
      assign out_dat_o = skid_vld_q ? skid_dat_q : in_dat_i;

      always_comb begin
         skid_vld_d = skid_vld_q;
         skid_dat_d = skid_dat_q;
         if (skid_vld_q) begin
            if (out_rdy_i) skid_vld_d = 1'b0;
         end else if (in_vld_i && !out_rdy_i) begin
            skid_vld_d = 1'b1;
            skid_dat_d = in_dat_i;
         end
         if (flush_i) skid_vld_d = 1'b0;
      end

      always_ff @(posedge clk_i) begin
         if (!rst_n_i) begin
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
         end else begin
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
         end
      end
   end else begin : g_both
      logic              vld_q, vld_d, skid_vld_q, skid_vld_d;
      logic [DATA_W-1:0] dat_q, dat_d, skid_dat_q, skid_dat_d;
      logic              in_fire, out_fire;

      assign in_rdy_o  = !skid_vld_q;
      assign out_vld_o = vld_q;
      assign out_dat_o = dat_q;
      assign in_fire   = in_vld_i && !skid_vld_q;
      assign out_fire  = vld_q && out_rdy_i;

      // The skid is only ever occupied behind a full forward register.
      always_comb begin
         vld_d      = vld_q;
         dat_d      = dat_q;
         skid_vld_d = skid_vld_q;
         skid_dat_d = skid_dat_q;
         if (skid_vld_q) begin
            if (out_fire) begin
               dat_d      = skid_dat_q;
               skid_vld_d = 1'b0;
            end
         end else if (in_fire) begin
            if (!vld_q || out_fire) begin
               vld_d = 1'b1;
               dat_d = in_dat_i;
            end else begin
               skid_vld_d = 1'b1;
               skid_dat_d = in_dat_i;
            end
         end else if (out_fire) begin
            vld_d = 1'b0;
         end
         if (flush_i) begin
            vld_d      = 1'b0;
            skid_vld_d = 1'b0;
         end
      end

      always_ff @(posedge clk_i) begin
         if (!rst_n_i) begin
            vld_q      <= 1'b0;
            dat_q      <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
         end else begin
            vld_q      <= vld_d;
            dat_q      <= dat_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
         end
      end
   end
endmodule

// File: rtl/handshake_pipe_chain.sv
// STAGES chained handshake stages with occupancy count, flush and reset gating of both ports.
// Latency STAGES (MODE 1/3) or 0 (MODE 2); MODE 0 is plain wires.
module handshake_pipe_chain
   import handshake_pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int STAGES = 2,
   parameter int MODE   = MODE_BOTH,
   parameter int OCC_W  = $clog2(2*STAGES+1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              master_valid,
   input  logic [DATA_W-1:0] master_data,
   output logic              master_ready,
   output logic              slave_valid,
   output logic [DATA_W-1:0] slave_data,
   input  logic              slave_ready,
   output logic [OCC_W-1:0]  occupancy
);
   if (STAGES < 1 || MODE < MODE_BYPASS || MODE > MODE_BOTH) begin : g_bad_param
      $error("handshake_pipe_chain: illegal STAGES or MODE");
   end

   if (MODE == MODE_BYPASS) begin : g_bypass
      logic unused_ok;
      assign unused_ok    = ^{clk, rst_n, flush};
      assign master_ready = slave_ready;
      assign slave_valid  = master_valid;
      assign slave_data   = master_data;
      assign occupancy    = '0;
   end else begin : g_chain
      logic              open_q;
      logic [STAGES:0]   vld, rdy;
      logic [DATA_W-1:0] dat [0:STAGES];
      logic              m_fire, s_fire;
      logic [OCC_W-1:0]  occ_q, occ_d;

      // Both ports are closed while in reset or flushing, so nothing moves or is counted.
      assign open_q       = rst_n && !flush;
      assign vld[0]       = master_valid && open_q;
      assign dat[0]       = master_data;
      assign master_ready = rdy[0] && open_q;
      assign rdy[STAGES]  = slave_ready && open_q;
      assign slave_valid  = vld[STAGES] && open_q;
      assign slave_data   = rst_n ? dat[STAGES] : '0;

      for (genvar i = 0; i < STAGES; i++) begin : g_stage
         handshake_pipe_stage #(
            .DATA_W (DATA_W),
            .MODE   (MODE)
         ) u_stage (
            .clk_i     (clk),
            .rst_n_i   (rst_n),
            .flush_i   (flush),
            .in_vld_i  (vld[i]),
            .in_dat_i  (dat[i]),
            .in_rdy_o  (rdy[i]),
            .out_vld_o (vld[i+1]),
            .out_dat_o (dat[i+1]),
            .out_rdy_i (rdy[i+1])
         );
      end

      assign m_fire    = master_valid && master_ready;
      assign s_fire    = slave_valid && slave_ready;
      assign occupancy = occ_q;

      always_comb begin
         occ_d = occ_q;
         if (m_fire && !s_fire)      occ_d = occ_q + OCC_W'(1);
         else if (s_fire && !m_fire) occ_d = occ_q - OCC_W'(1);
         if (flush) occ_d = '0;
      end

      always_ff @(posedge clk) begin
         if (!rst_n) occ_q <= '0;
         else        occ_q <= occ_d;
      end
   end
endmodule

// File: tb/tb_handshake_pipe_chain.sv
// Directed/table-driven bench for handshake_pipe_chain in all four modes plus a scoreboarded random run.
module tb_handshake_pipe_chain;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // MODE 3, STAGES 2
   logic mv3 = 0, mr3, sv3, sr3 = 0, f3 = 0;
   logic [31:0] md3 = '0, sd3;
   logic [2:0] occ3;
   // MODE 1, STAGES 3
   logic mv1 = 0, mr1, sv1, sr1 = 0, f1 = 0;
   logic [31:0] md1 = '0, sd1;
   logic [2:0] occ1;
   // MODE 2, STAGES 1
   logic mv2 = 0, mr2, sv2, sr2 = 0, f2 = 0;
   logic [31:0] md2 = '0, sd2;
   logic [1:0] occ2;
   // MODE 0, STAGES 2
   logic mv0 = 0, mr0, sv0, sr0 = 0, f0 = 0;
   logic [31:0] md0 = '0, sd0;
   logic [2:0] occ0;

   handshake_pipe_chain #(.DATA_W(32), .STAGES(2), .MODE(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .flush(f3), .master_valid(mv3), .master_data(md3),
      .master_ready(mr3), .slave_valid(sv3), .slave_data(sd3), .slave_ready(sr3), .occupancy(occ3));
   handshake_pipe_chain #(.DATA_W(32), .STAGES(3), .MODE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .flush(f1), .master_valid(mv1), .master_data(md1),
      .master_ready(mr1), .slave_valid(sv1), .slave_data(sd1), .slave_ready(sr1), .occupancy(occ1));
   handshake_pipe_chain #(.DATA_W(32), .STAGES(1), .MODE(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .flush(f2), .master_valid(mv2), .master_data(md2),
      .master_ready(mr2), .slave_valid(sv2), .slave_data(sd2), .slave_ready(sr2), .occupancy(occ2));
   handshake_pipe_chain #(.DATA_W(32), .STAGES(2), .MODE(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .flush(f0), .master_valid(mv0), .master_data(md0),
      .master_ready(mr0), .slave_valid(sv0), .slave_data(sd0), .slave_ready(sr0), .occupancy(occ0));

   typedef struct {
      logic        mv;
      logic [31:0] md;
      logic        sr;
      logic        mr;
      logic        sv;
      logic [31:0] sd;
      int          occ;
   } vec_t;

   vec_t tab2 [10];
   vec_t tab0 [4];

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Scoreboard state for the MODE 3 instance.
   logic [31:0] q3 [$];
   logic [31:0] nxt3 = 32'd1;
   logic [31:0] stall_dat3 = '0;
   bit pend3 = 0;
   bit stall3 = 0;
   int pushed3 = 0;

   task automatic cyc3(input bit v, input bit r);
      @(negedge clk);
      if (!pend3) md3 = nxt3;
      mv3 = pend3 | v;
      sr3 = r;
      #1;
      chk("occ3_model", 32'(occ3), 32'(q3.size()));
      chk("occ3_bound", 32'(occ3 <= 3'd4), 32'd1);
      if (stall3) begin
         chk("sv3_hold", 32'(sv3), 32'd1);
         chk("sd3_hold", sd3, stall_dat3);
      end
      if (mv3 && mr3) begin
         q3.push_back(md3);
         nxt3++;
         pushed3++;
         pend3 = 0;
      end else begin
         pend3 = mv3;
      end
      if (sv3 && sr3) begin
         if (q3.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sd3_unexpected: got %0h, expected no word", sd3);
         end else begin
            chk("sd3_order", sd3, q3.pop_front());
         end
      end
      stall3 = sv3 && !sr3;
      stall_dat3 = sd3;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      void'($urandom(0));
      // MODE 2 alternating valid/ready, then a skid-full stall.
      tab2[0] = '{1'b1, 32'd11, 1'b0, 1'b1, 1'b1, 32'd11, 0};
      tab2[1] = '{1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 32'd11, 1};
      tab2[2] = '{1'b1, 32'd22, 1'b0, 1'b1, 1'b1, 32'd22, 0};
      tab2[3] = '{1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 32'd22, 1};
      tab2[4] = '{1'b1, 32'd33, 1'b0, 1'b1, 1'b1, 32'd33, 0};
      tab2[5] = '{1'b1, 32'd44, 1'b0, 1'b0, 1'b1, 32'd33, 1};
      tab2[6] = '{1'b1, 32'd44, 1'b1, 1'b0, 1'b1, 32'd33, 1};
      tab2[7] = '{1'b1, 32'd44, 1'b1, 1'b1, 1'b1, 32'd44, 0};
      tab2[8] = '{1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 32'd0,  0};
      tab2[9] = '{1'b0, 32'd55, 1'b0, 1'b1, 1'b0, 32'd0,  0};
      // MODE 0 pass-through, flush held high throughout.
      tab0[0] = '{1'b1, 32'hA5A5_A5A5, 1'b1, 1'b1, 1'b1, 32'hA5A5_A5A5, 0};
      tab0[1] = '{1'b0, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 32'h1234_5678, 0};
      tab0[2] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 0};
      tab0[3] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 0};

      // Reset state
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_sv3", 32'(sv3), 32'd0);
      chk("rst_sd3", sd3, 32'd0);
      chk("rst_mr3", 32'(mr3), 32'd0);
      chk("rst_occ3", 32'(occ3), 32'd0);
      chk("rst_mr1", 32'(mr1), 32'd0);
      chk("rst_mr2", 32'(mr2), 32'd0);
      rst_n = 1'b1;

      // Bypass
      f0 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         mv0 = tab0[i].mv; md0 = tab0[i].md; sr0 = tab0[i].sr;
         #1;
         chk("byp_mr", 32'(mr0), 32'(tab0[i].mr));
         chk("byp_sv", 32'(sv0), 32'(tab0[i].sv));
         chk("byp_sd", sd0, tab0[i].sd);
         chk("byp_occ", 32'(occ0), 32'(tab0[i].occ));
      end
      f0 = 1'b0;

      // MODE 2 table
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         mv2 = tab2[i].mv; md2 = tab2[i].md; sr2 = tab2[i].sr;
         #1;
         chk("m2_mr", 32'(mr2), 32'(tab2[i].mr));
         chk("m2_sv", 32'(sv2), 32'(tab2[i].sv));
         if (tab2[i].sv) chk("m2_sd", sd2, tab2[i].sd);
         chk("m2_occ", 32'(occ2), 32'(tab2[i].occ));
      end

      // MODE 1 latency: first word after 3 edges, then one per cycle
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         mv1 = (c < 5);
         md1 = 32'hDEAD_BEEF + 32'(c);
         sr1 = 1'b1;
         #1;
         chk("lat_mr", 32'(mr1), 32'd1);
         chk("lat_sv", 32'(sv1), 32'(c >= 3 && c < 8));
         if (c >= 3 && c < 8) chk("lat_sd", sd1, 32'hDEAD_BEEF + 32'(c - 3));
      end

      // MODE 3 fill under back-pressure
      for (int i = 0; i < 8; i++) cyc3(1'b1, 1'b0);
      chk("fill_accepted", 32'(pushed3), 32'd4);
      @(negedge clk);
      #1;
      chk("fill_occ", 32'(occ3), 32'd4);
      chk("fill_mr", 32'(mr3), 32'd0);
      chk("fill_head", sd3, 32'd1);
      for (int i = 0; i < 12; i++) cyc3(1'b1, 1'b1);
      for (int i = 0; i < 10; i++) cyc3(1'b0, 1'b1);
      chk("fill_drained", 32'(q3.size()), 32'd0);

      // Flush with 3 entries held
      for (int i = 0; i < 3; i++) cyc3(1'b1, 1'b0);
      chk("flush_held", 32'(q3.size()), 32'd3);
      @(negedge clk);
      f3 = 1'b1; mv3 = 1'b1; md3 = nxt3; sr3 = 1'b1;
      #1;
      chk("flush_mr", 32'(mr3), 32'd0);
      chk("flush_sv", 32'(sv3), 32'd0);
      @(negedge clk);
      f3 = 1'b0; mv3 = 1'b0;
      #1;
      chk("flush_occ", 32'(occ3), 32'd0);
      chk("flush_sv_after", 32'(sv3), 32'd0);
      q3.delete();
      pend3 = 0;
      stall3 = 0;
      for (int i = 0; i < 6; i++) cyc3(1'b1, 1'b1);
      for (int i = 0; i < 10; i++) cyc3(1'b0, 1'b1);

      // Random traffic, 30000 master transfers
      pushed3 = 0;
      for (int c = 0; c < 60000 && pushed3 < 30000; c++)
         cyc3($urandom_range(3) != 0, $urandom_range(3) != 0);
      for (int i = 0; i < 20 && (q3.size() != 0 || pend3); i++) cyc3(1'b0, 1'b1);
      chk("rand_count", 32'(pushed3 >= 30000), 32'd1);
      chk("rand_drained", 32'(q3.size()), 32'd0);

      // Mid-stream reset with the chain full
      for (int i = 0; i < 6; i++) cyc3(1'b1, 1'b0);
      @(negedge clk);
      rst_n = 1'b0; f3 = 1'b1; sr3 = 1'b0;
      @(negedge clk);
      #1;
      chk("mrst_sv", 32'(sv3), 32'd0);
      chk("mrst_sd", sd3, 32'd0);
      chk("mrst_mr", 32'(mr3), 32'd0);
      chk("mrst_occ", 32'(occ3), 32'd0);
      rst_n = 1'b1; f3 = 1'b0; mv3 = 1'b0;
      @(negedge clk);
      #1;
      chk("mrst_after_mr", 32'(mr3), 32'd1);
      chk("mrst_after_sv", 32'(sv3), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
